// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined two's-complement adder/subtractor with saturation and valid/ready handshake
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int SLICES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / SLICES;

  logic             stall;
  logic             fin_v;
  logic             fin_c;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_sum;

  // A result waiting on a busy consumer freezes the whole pipeline.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  genvar k;
  generate
    for (k = 0; k < SLICES; k++) begin : g_st
      // Operand bits not yet consumed, including this stage's slice.
      localparam int RW = WIDTH - k * SW;

      logic [RW-1:0]         a_in;
      logic [RW-1:0]         bx_in;
      logic                  c_in;
      logic                  sat_in;
      logic                  v_in;
      logic [SW-1:0]         slice_sum;
      logic                  slice_c;
      logic [(k+1)*SW-1:0]   s_done;

      // Add this stage's slice using the carry handed over by the previous stage.
      assign {slice_c, slice_sum} = {1'b0, a_in[SW-1:0]} + {1'b0, bx_in[SW-1:0]}
                                    + {{SW{1'b0}}, c_in};

      if (k == 0) begin : g_src
        // Subtraction is A + ~B + ~borrow, so the inversion happens once at entry.
        assign a_in   = a;
        assign bx_in  = sub ? ~b : b;
        assign c_in   = sub ? ~cin : cin;
        assign sat_in = sat;
        assign v_in   = in_valid;
        assign s_done = slice_sum;
      end else begin : g_src
        assign a_in   = g_st[k-1].g_reg.a_q;
        assign bx_in  = g_st[k-1].g_reg.bx_q;
        assign c_in   = g_st[k-1].g_reg.c_q;
        assign sat_in = g_st[k-1].g_reg.sat_q;
        assign v_in   = g_st[k-1].g_reg.v_q;
        assign s_done = {slice_sum, g_st[k-1].g_reg.s_q};
      end

      if (k < SLICES - 1) begin : g_reg
        logic [RW-SW-1:0]    a_q;
        logic [RW-SW-1:0]    bx_q;
        logic [(k+1)*SW-1:0] s_q;
        logic                c_q;
        logic                sat_q;
        logic                v_q;

        // Intermediate stage register: upper operand bits, finished sum bits and carry move on together.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_q   <= '0;
            bx_q  <= '0;
            s_q   <= '0;
            c_q   <= 1'b0;
            sat_q <= 1'b0;
            v_q   <= 1'b0;
          end else if (!stall) begin
            a_q   <= a_in[RW-1:SW];
            bx_q  <= bx_in[RW-1:SW];
            s_q   <= s_done;
            c_q   <= slice_c;
            sat_q <= sat_in;
            v_q   <= v_in;
          end
        end
      end else begin : g_out
        // Last slice holds the operand sign bits, so overflow and clamping are resolved here.
        assign fin_v   = v_in;
        assign fin_c   = slice_c;
        assign fin_ovf = (a_in[SW-1] == bx_in[SW-1]) && (slice_sum[SW-1] != a_in[SW-1]);
        assign fin_sum = (sat_in && fin_ovf)
                         ? (a_in[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                         : s_done;
      end
    end
  endgenerate

  // Output register drives the ports directly and holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      out_valid <= fin_v;
      sum       <= fin_sum;
      cout      <= fin_c;
      ovf       <= fin_ovf;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - scoreboard bench for addsub_pipe (16/2 and 8/1 instances)
module tb_addsub_pipe;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, sub, sat, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic        in_valid_8, in_ready_8, cin_8, sub_8, sat_8, out_valid_8, out_ready_8, cout_8, ovf_8;
  logic [7:0]  a_8, b_8, sum_8;

  addsub_pipe #(.WIDTH(16), .SLICES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  addsub_pipe #(.WIDTH(8), .SLICES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .a(a_8), .b(b_8),
    .cin(cin_8), .sub(sub_8), .sat(sat_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .sum(sum_8), .cout(cout_8), .ovf(ovf_8));

  exp_t q16[$];
  exp_t q8[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic held_v = 1'b0;
  exp_t held;
  bit   rnd_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
    exp_t r;
    r.sum  = s;
    r.cout = c;
    r.ovf  = o;
    return r;
  endfunction

  // Reference: exact signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(input int w, input logic [15:0] ua, input logic [15:0] ub,
                                 input logic ci, input logic su, input logic sa_en);
    exp_t   r;
    longint m  = longint'(1) << w;
    longint ia = longint'(ua) & (m - 1);
    longint ib = longint'(ub) & (m - 1);
    longint sa = (ia >= m / 2) ? ia - m : ia;
    longint sb = (ib >= m / 2) ? ib - m : ib;
    longint c  = longint'(ci);
    longint ex = su ? sa - sb - c : sa + sb + c;
    longint ru = su ? ia - ib - c : ia + ib + c;
    longint hi = m / 2 - 1;
    longint lo = -(m / 2);
    longint res;
    r.ovf  = (ex > hi) || (ex < lo);
    r.cout = su ? (ia >= ib + c) : (ru >= m);
    res    = (sa_en && r.ovf) ? ((ex > hi) ? hi : lo) : ru;
    r.sum  = 16'(res & (m - 1));
    return r;
  endfunction

  task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic ts, input logic tsat, input exp_t e);
    bit got = 0;
    a = ta; b = tb; cin = tc; sub = ts; sat = tsat; in_valid = 1'b1;
    q16.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      n_vec++; n_fail++;
      $display("FAIL accept16_timeout: in_ready stayed 0, expected 1 within 50 cycles");
      void'(q16.pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic ts, input logic tsat, input exp_t e);
    bit got = 0;
    a_8 = ta; b_8 = tb; cin_8 = tc; sub_8 = ts; sat_8 = tsat; in_valid_8 = 1'b1;
    q8.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_8) begin got = 1; break; end
    end
    if (!got) begin
      n_vec++; n_fail++;
      $display("FAIL accept8_timeout: in_ready stayed 0, expected 1 within 50 cycles");
      void'(q8.pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q16.size() == 0 && q8.size() == 0) break;
      @(posedge clk); #1;
    end
  endtask

  // Monitor for the 16-bit pipeline: pop on transfer, and check outputs stay frozen while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q16.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL out16_unexpected: got sum 0x%0h, expected no output", sum);
      end else begin
        e = q16.pop_front();
        chk("out16_sum", 32'(sum), 32'(e.sum));
        chk("out16_cout", 32'(cout), 32'(e.cout));
        chk("out16_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    if (!rst && out_valid && !out_ready) begin
      if (held_v) begin
        chk("hold_sum", 32'(sum), 32'(held.sum));
        chk("hold_flags", {30'b0, cout, ovf}, {30'b0, held.cout, held.ovf});
      end
      held_v = 1'b1;
      held   = mk(sum, cout, ovf);
    end else begin
      held_v = 1'b0;
    end
  end

  // Monitor for the 8-bit single-stage instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_8 && out_ready_8) begin
      if (q8.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL out8_unexpected: got sum 0x%0h, expected no output", sum_8);
      end else begin
        e = q8.pop_front();
        chk("out8_sum", 32'(sum_8), 32'(e.sum));
        chk("out8_cout", 32'(cout_8), 32'(e.cout));
        chk("out8_ovf", 32'(ovf_8), 32'(e.ovf));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; sat = 0; out_ready = 1;
    in_valid_8 = 0; a_8 = 0; b_8 = 0; cin_8 = 0; sub_8 = 0; sat_8 = 0; out_ready_8 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", {30'b0, cout, ovf}, 32'd0);
    chk("rst_out_valid8", 32'(out_valid_8), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Carry across the slice boundary, with latency of two edges.
    send16(16'h00FF, 16'h0001, 0, 0, 0, mk(16'h0100, 0, 0));
    in_valid = 0;
    @(negedge clk);
    chk("lat16_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat16_due", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Overflow, saturation and subtraction corners, back to back.
    send16(16'h7FFF, 16'h0001, 0, 0, 0, mk(16'h8000, 0, 1));
    send16(16'h7FFF, 16'h0001, 0, 0, 1, mk(16'h7FFF, 0, 1));
    send16(16'h0000, 16'h0001, 0, 1, 0, mk(16'hFFFF, 0, 0));
    send16(16'h8000, 16'h0001, 0, 1, 1, mk(16'h8000, 1, 1));
    send16(16'h0005, 16'h0003, 1, 1, 0, mk(16'h0001, 1, 0));
    send16(16'hFFFF, 16'h0001, 0, 0, 0, mk(16'h0000, 1, 0));
    in_valid = 0;
    drain();

    // Backpressure: six ops, consumer stalls for three cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send16(16'h0101 * 16'(i), 16'h0010, 0, 0, 0, mk(16'h0010 + 16'h0101 * 16'(i), 0, 0));
        in_valid = 0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
          @(posedge clk); #1;
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_in_ready_resume", 32'(in_ready), 32'd1);
      end
    join
    drain();

    // Reset with two ops in flight discards both.
    send16(16'h1234, 16'h1111, 0, 0, 0, mk(16'h2345, 0, 0));
    send16(16'h0F0F, 16'h0101, 0, 0, 0, mk(16'h1010, 0, 0));
    #1;
    rst = 1'b1;
    in_valid = 0;
    q16.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random stream with random consumer stalls.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [15:0] ra, rb;
          logic rc, rs, rt;
          ra = 16'($urandom); rb = 16'($urandom);
          rc = 1'($urandom); rs = 1'($urandom); rt = 1'($urandom);
          send16(ra, rb, rc, rs, rt, model(16, ra, rb, rc, rs, rt));
        end
        in_valid = 0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain();

    // Single-stage 8-bit instance: one-cycle latency and wrap-around carry.
    send8(8'hFF, 8'h01, 0, 0, 0, mk(16'h0000, 1, 0));
    in_valid_8 = 0;
    @(negedge clk);
    chk("lat8_due", 32'(out_valid_8), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic rc, rs, rt;
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom); rt = 1'($urandom);
      send8(ra, rb, rc, rs, rt, model(8, {8'h00, ra}, {8'h00, rb}, rc, rs, rt));
    end
    in_valid_8 = 0;
    drain();
    repeat (3) @(posedge clk);

    chk("q16_empty", 32'(q16.size()), 32'd0);
    chk("q8_empty", 32'(q8.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
